// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage MIPS core: valid, control flags and payload,
// with flush/stall-vector handling and saturating per-stage event counters.
module pipe_stage_reg #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 128,
    parameter int STALL_W    = 6,
    parameter int STAGE      = 4,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                cnt_clr,
    output logic                out_valid,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]    adv_cnt,
    output logic [CNT_W-1:0]    hold_cnt,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } act_t;

    logic s_cur;
    logic s_nxt;
    act_t act;

    logic              valid_p0;
    logic [CTRL_W-1:0] ctrl_p0;
    logic [DATA_W-1:0] data_p0;

    logic [CNT_W-1:0] adv_q, hold_q, bubble_q, flush_q;

    // Only two bits of the stall vector matter to any one stage.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign s_cur = stall[STAGE];

    // The last stage has no downstream neighbour, so it can never hold.
    generate
        if (STAGE + 1 < STALL_W) begin : g_has_next
            assign s_nxt = stall[STAGE+1];
        end else begin : g_last_stage
            assign s_nxt = 1'b0;
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        act = ACT_ADVANCE;
        if (flush)
            act = ACT_FLUSH;
        else if (s_cur && !s_nxt)
            act = ACT_BUBBLE;
        else if (s_cur)
            act = ACT_HOLD;
    end

    // ---- stage register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_p0 <= 1'b0;
            ctrl_p0  <= '0;
            data_p0  <= '0;
        end else begin
            case (act)
                ACT_ADVANCE: begin
                    valid_p0 <= in_valid;
                    ctrl_p0  <= in_ctrl;
                    data_p0  <= in_data;
                end
                ACT_FLUSH, ACT_BUBBLE: begin
                    valid_p0 <= 1'b0;
                    ctrl_p0  <= '0;
                    if (CLEAR_DATA)
                        data_p0 <= '0;
                end
                default: ;
            endcase
        end
    end

    // ---- event counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adv_q    <= '0;
            hold_q   <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else if (cnt_clr) begin
            adv_q    <= '0;
            hold_q   <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            case (act)
                ACT_ADVANCE: if (in_valid) adv_q <= sat_inc(adv_q);
                ACT_HOLD:    hold_q   <= sat_inc(hold_q);
                ACT_BUBBLE:  bubble_q <= sat_inc(bubble_q);
                ACT_FLUSH:   flush_q  <= sat_inc(flush_q);
                default: ;
            endcase
        end
    end

    assign out_valid  = valid_p0;
    assign out_ctrl   = ctrl_p0;
    assign out_data   = data_p0;
    assign adv_cnt    = adv_q;
    assign hold_cnt   = hold_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four instances (stage 4, stage 3 with 4-bit counters,
// stage 4 retaining data, last stage 5) share one stimulus; expectations queued per instance.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic         flush;
    logic         in_valid;
    logic [7:0]   in_ctrl;
    logic [127:0] in_data;
    logic         cnt_clr;

    logic v4, v3, vn, v5;
    logic [7:0] c4, c3, cn, c5;
    logic [127:0] d4, d3, dn, d5;
    logic [15:0] a4, h4, b4, f4, an, hn, bn, fn, a5, h5, b5, f5;
    logic [3:0]  a3, h3, b3, f3;

    always #5 clk = ~clk;

    pipe_stage_reg #(.STAGE(4), .CLEAR_DATA(1'b1), .CNT_W(16)) u4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_valid(v4), .out_ctrl(c4), .out_data(d4),
        .adv_cnt(a4), .hold_cnt(h4), .bubble_cnt(b4), .flush_cnt(f4));

    pipe_stage_reg #(.STAGE(3), .CLEAR_DATA(1'b1), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_valid(v3), .out_ctrl(c3), .out_data(d3),
        .adv_cnt(a3), .hold_cnt(h3), .bubble_cnt(b3), .flush_cnt(f3));

    pipe_stage_reg #(.STAGE(4), .CLEAR_DATA(1'b0), .CNT_W(16)) u_nc (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_valid(vn), .out_ctrl(cn), .out_data(dn),
        .adv_cnt(an), .hold_cnt(hn), .bubble_cnt(bn), .flush_cnt(fn));

    pipe_stage_reg #(.STAGE(5), .CLEAR_DATA(1'b1), .CNT_W(16)) u5 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_valid(v5), .out_ctrl(c5), .out_data(d5),
        .adv_cnt(a5), .hold_cnt(h5), .bubble_cnt(b5), .flush_cnt(f5));

    typedef struct {
        int           dut;
        logic         v;
        logic [7:0]   c;
        logic [127:0] d;
        logic [15:0]  a, h, b, f;
        string        nm;
    } exp_t;

    typedef struct {
        logic [5:0]   st;
        logic         fl, iv;
        logic [7:0]   c;
        logic [127:0] d;
        logic         clr;
        logic         ev;
        logic [7:0]   ec;
        logic [127:0] ed;
        logic [15:0]  ea, eh, eb, ef;
    } row_t;

    exp_t q[$];
    row_t tbl[$];
    int errors = 0;
    int checks = 0;

    task automatic push(input int dut, input logic v, input logic [7:0] c, input logic [127:0] d,
                        input logic [15:0] a, h, b, f, input string nm);
        exp_t e;
        e.dut = dut; e.v = v; e.c = c; e.d = d;
        e.a = a; e.h = h; e.b = b; e.f = f; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic compare_all();
        exp_t e;
        logic [200:0] act, req;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.dut)
                4: act = {v4, c4, d4, a4, h4, b4, f4};
                3: act = {v3, c3, d3, 16'(a3), 16'(h3), 16'(b3), 16'(f3)};
                1: act = {vn, cn, dn, an, hn, bn, fn};
                default: act = {v5, c5, d5, a5, h5, b5, f5};
            endcase
            req = {e.v, e.c, e.d, e.a, e.h, e.b, e.f};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL %s dut%0d got v=%b c=%h d=%h adv=%h hold=%h bub=%h fl=%h want v=%b c=%h d=%h adv=%h hold=%h bub=%h fl=%h",
                         e.nm, e.dut, act[200], act[199:192], act[191:64], act[63:48], act[47:32], act[31:16], act[15:0],
                         e.v, e.c, e.d, e.a, e.h, e.b, e.f);
            end
        end
    endtask

    task automatic drive(input logic [5:0] st, input logic f, input logic iv, input logic [7:0] c,
                         input logic [127:0] d, input logic clr);
        stall = st; flush = f; in_valid = iv; in_ctrl = c; in_data = d; cnt_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic add_row(input logic [5:0] st, input logic fl, iv, input logic [7:0] c,
                           input logic [127:0] d, input logic clr, input logic ev,
                           input logic [7:0] ec, input logic [127:0] ed, input logic [15:0] ea, eh, eb, ef);
        row_t r;
        r.st = st; r.fl = fl; r.iv = iv; r.c = c; r.d = d; r.clr = clr;
        r.ev = ev; r.ec = ec; r.ed = ed; r.ea = ea; r.eh = eh; r.eb = eb; r.ef = ef;
        tbl.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(6'b0, 1'b0, 1'b0, 8'h00, 128'h0, 1'b0);

        // stage-4 main sequence: stimulus and expected outputs/counters
        add_row(6'b000000, 0, 1, 8'hA5, 128'h1234, 0, 1, 8'hA5, 128'h1234, 1, 0, 0, 0);
        add_row(6'b000000, 0, 1, 8'h3C, 128'hBEEF, 0, 1, 8'h3C, 128'hBEEF, 2, 0, 0, 0);
        add_row(6'b000000, 0, 0, 8'hFF, 128'h5555, 0, 0, 8'hFF, 128'h5555, 2, 0, 0, 0);
        add_row(6'b000000, 0, 1, 8'h11, 128'hAAAA, 0, 1, 8'h11, 128'hAAAA, 3, 0, 0, 0);
        add_row(6'b011111, 0, 1, 8'h99, 128'h9999, 0, 0, 8'h00, 128'h0,    3, 0, 1, 0);
        add_row(6'b011111, 0, 1, 8'h99, 128'h9999, 0, 0, 8'h00, 128'h0,    3, 0, 2, 0);
        add_row(6'b011111, 0, 1, 8'h99, 128'h9999, 0, 0, 8'h00, 128'h0,    3, 0, 3, 0);
        add_row(6'b100000, 0, 1, 8'h22, 128'h7777, 0, 1, 8'h22, 128'h7777, 4, 0, 3, 0);
        add_row(6'b000000, 0, 1, 8'h44, 128'h4444, 0, 1, 8'h44, 128'h4444, 5, 0, 3, 0);
        add_row(6'b110000, 0, 1, 8'h55, 128'h5555, 0, 1, 8'h44, 128'h4444, 5, 1, 3, 0);
        add_row(6'b111111, 1, 1, 8'h66, 128'h6666, 0, 0, 8'h00, 128'h0,    5, 1, 3, 1);
        add_row(6'b000000, 0, 1, 8'h66, 128'h0001, 1, 1, 8'h66, 128'h0001, 0, 0, 0, 0);
        add_row(6'b000000, 0, 1, 8'h77, 128'h0002, 0, 1, 8'h77, 128'h0002, 1, 0, 0, 0);
        add_row(6'b000000, 1, 1, 8'h88, 128'h0008, 0, 0, 8'h00, 128'h0,    1, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        push(4, 0, 8'h00, 128'h0, 0, 0, 0, 0, "reset_state");
        compare_all();
        rst = 1'b0;

        // load, then assert reset mid-cycle: outputs must clear before the next edge
        drive(6'b0, 1'b0, 1'b1, 8'h5A, 128'hF0F0, 1'b0);
        push(4, 1, 8'h5A, 128'hF0F0, 1, 0, 0, 0, "pre_reset_load");
        tick();
        #3 rst = 1'b1;
        #1;
        push(4, 0, 8'h00, 128'h0, 0, 0, 0, 0, "async_reset_u4");
        push(1, 0, 8'h00, 128'h0, 0, 0, 0, 0, "async_reset_keepdata");
        push(3, 0, 8'h00, 128'h0, 0, 0, 0, 0, "async_reset_u3");
        push(5, 0, 8'h00, 128'h0, 0, 0, 0, 0, "async_reset_u5");
        compare_all();
        #1 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].fl, tbl[i].iv, tbl[i].c, tbl[i].d, tbl[i].clr);
            push(4, tbl[i].ev, tbl[i].ec, tbl[i].ed, tbl[i].ea, tbl[i].eh, tbl[i].eb, tbl[i].ef,
                 $sformatf("table_row%0d", i));
            tick();
        end

        // stage 3: boundary below it stalled too, so it holds; 4-bit hold counter saturates
        drive(6'b000000, 1'b0, 1'b1, 8'hC3, 128'h3333, 1'b1);
        push(3, 1, 8'hC3, 128'h3333, 0, 0, 0, 0, "hold_load");
        tick();
        for (int n = 1; n <= 20; n++) begin
            drive(6'b011111, 1'b0, 1'b1, 8'(n), 128'(n), 1'b0);
            push(3, 1, 8'hC3, 128'h3333, 0, 16'((n > 15) ? 15 : n), 0, 0, $sformatf("hold_cycle%0d", n));
            tick();
        end
        drive(6'b011111, 1'b0, 1'b1, 8'h00, 128'h0, 1'b1);
        push(3, 1, 8'hC3, 128'h3333, 0, 0, 0, 0, "clr_over_hold");
        tick();
        drive(6'b111111, 1'b1, 1'b1, 8'h00, 128'h0, 1'b0);
        push(3, 0, 8'h00, 128'h0, 0, 0, 0, 1, "flush_over_hold");
        tick();

        // retaining-data variant: bubble and flush clear valid/ctrl only
        drive(6'b000000, 1'b0, 1'b1, 8'h5A, 128'hDEAD, 1'b1);
        push(1, 1, 8'h5A, 128'hDEAD, 0, 0, 0, 0, "keep_load");
        tick();
        drive(6'b011111, 1'b0, 1'b1, 8'hBB, 128'hBBBB, 1'b0);
        push(1, 0, 8'h00, 128'hDEAD, 0, 0, 1, 0, "keep_bubble");
        tick();
        drive(6'b111111, 1'b1, 1'b1, 8'hBB, 128'hBBBB, 1'b0);
        push(1, 0, 8'h00, 128'hDEAD, 0, 0, 1, 1, "keep_flush");
        tick();

        // last stage: own stall bit always yields a bubble
        drive(6'b000000, 1'b0, 1'b1, 8'hA1, 128'h5151, 1'b1);
        push(5, 1, 8'hA1, 128'h5151, 0, 0, 0, 0, "last_load");
        tick();
        drive(6'b100000, 1'b0, 1'b1, 8'hCC, 128'hCCCC, 1'b0);
        push(5, 0, 8'h00, 128'h0, 0, 0, 1, 0, "last_bubble1");
        tick();
        drive(6'b111111, 1'b0, 1'b1, 8'hCC, 128'hCCCC, 1'b0);
        push(5, 0, 8'h00, 128'h0, 0, 0, 2, 0, "last_bubble2");
        tick();
        drive(6'b000000, 1'b0, 1'b1, 8'hB2, 128'h6262, 1'b0);
        push(5, 1, 8'hB2, 128'h6262, 1, 0, 2, 0, "last_reload");
        tick();
        drive(6'b111111, 1'b0, 1'b1, 8'hCC, 128'hCCCC, 1'b0);
        push(5, 0, 8'h00, 128'h0, 1, 0, 3, 0, "last_never_hold");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
